// File: rtl/fpu_wb_scheduler_pkg.sv
// Shared definitions for the FP issue/writeback scheduler: op classes,
// default per-class latencies, default non-pipelined mask and slot layout.
package fpu_wb_scheduler_pkg;

  localparam int unsigned NClass = 8;
  localparam int unsigned LatW   = 5;

  typedef enum logic [2:0] {
    ClsAddSub = 3'd0,
    ClsMul    = 3'd1,
    ClsFma    = 3'd2,
    ClsDiv    = 3'd3,
    ClsSqrt   = 3'd4,
    ClsCvt    = 3'd5,
    ClsCmp    = 3'd6,
    ClsMisc   = 3'd7
  } fp_class_e;

  // Unit latencies in cycles from accept to writeback.
  localparam int unsigned LatAddSub = 4;
  localparam int unsigned LatMul    = 5;
  localparam int unsigned LatFma    = 6;
  localparam int unsigned LatDiv    = 12;
  localparam int unsigned LatSqrt   = 14;
  localparam int unsigned LatCvt    = 3;
  localparam int unsigned LatCmp    = 3;
  localparam int unsigned LatMisc   = 2;

  // Class 0 occupies the least significant latency field.
  localparam logic [NClass*LatW-1:0] DefaultClassLat = {
    5'(LatMisc), 5'(LatCmp), 5'(LatCvt), 5'(LatSqrt),
    5'(LatDiv), 5'(LatFma), 5'(LatMul), 5'(LatAddSub)
  };

  // Divide and square root hold their unit for the whole latency.
  localparam logic [NClass-1:0] DefaultIterMask = 8'b0001_1000;

  // One reservation slot at the default tag width.
  typedef struct packed {
    logic      valid;
    logic [4:0] tag;
    fp_class_e cls;
  } resv_slot_t;

  localparam int unsigned SlotW = $bits(resv_slot_t);

endpackage

// File: rtl/fpu_resv_slot_array.sv
// Latency-reservation shift register: slot k writes back k cycles from now.
// Handles insertion at a latency-selected slot, flush, tag match and occupancy.
module fpu_resv_slot_array #(
  parameter int unsigned MAX_LAT = 16,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned CLS_W   = 3,
  parameter int unsigned IDX_W   = $clog2(MAX_LAT),
  parameter int unsigned CNT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               ins_en,
  input  logic [IDX_W-1:0]   ins_idx,
  input  logic [TAG_W-1:0]   ins_tag,
  input  logic [CLS_W-1:0]   ins_cls,
  input  logic [TAG_W-1:0]   query_tag,
  output logic [MAX_LAT-1:0] slot_valid,
  output logic [TAG_W-1:0]   head_tag,
  output logic [CLS_W-1:0]   head_cls,
  output logic               query_hit,
  output logic [CNT_W-1:0]   count_next
);

  logic [MAX_LAT-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [MAX_LAT];
  logic [TAG_W-1:0]   tag_d [MAX_LAT];
  logic [CLS_W-1:0]   cls_q [MAX_LAT];
  logic [CLS_W-1:0]   cls_d [MAX_LAT];

  // Next state: shift toward slot 0, overwrite the insert slot, flush clears valids.
  always_comb begin
    valid_d = {1'b0, valid_q[MAX_LAT-1:1]};
    for (int unsigned k = 0; k < MAX_LAT - 1; k++) begin
      tag_d[k] = tag_q[k+1];
      cls_d[k] = cls_q[k+1];
    end
    tag_d[MAX_LAT-1] = '0;
    cls_d[MAX_LAT-1] = '0;
    if (ins_en) begin
      valid_d[ins_idx] = 1'b1;
      tag_d[ins_idx]   = ins_tag;
      cls_d[ins_idx]   = ins_cls;
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // Slot registers; reset discards every pending writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < MAX_LAT; k++) begin
        tag_q[k] <= '0;
        cls_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < MAX_LAT; k++) begin
        tag_q[k] <= tag_d[k];
        cls_q[k] <= cls_d[k];
      end
    end
  end

  // RAW query over current slots and occupancy of the next state.
  always_comb begin
    query_hit  = 1'b0;
    count_next = '0;
    for (int unsigned k = 0; k < MAX_LAT; k++) begin
      if (valid_q[k] && (tag_q[k] == query_tag)) begin
        query_hit = 1'b1;
      end
      count_next = count_next + CNT_W'(valid_d[k]);
    end
  end

  assign slot_valid = valid_q;
  assign head_tag   = tag_q[0];
  assign head_cls   = cls_q[0];

endmodule

// File: rtl/fpu_wb_scheduler.sv
// FP issue/writeback scheduler: gates issue so each op lands in a free
// writeback slot, serialises non-pipelined units and muxes the unit result.
module fpu_wb_scheduler
  import fpu_wb_scheduler_pkg::*;
#(
  parameter int unsigned             XLEN      = 32,
  parameter int unsigned             TAG_W     = 5,
  parameter int unsigned             N_CLASS   = NClass,
  parameter int unsigned             MAX_LAT   = 16,
  parameter int unsigned             LAT_W     = LatW,
  parameter logic [N_CLASS*LAT_W-1:0] CLASS_LAT = DefaultClassLat,
  parameter logic [N_CLASS-1:0]      ITER_MASK = DefaultIterMask
) (
  input  logic                           clock_float_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic                           issue_valid_i,
  output logic                           issue_ready_o,
  input  logic [$clog2(N_CLASS)-1:0]     issue_class_i,
  input  logic [TAG_W-1:0]               issue_tag_i,
  input  logic [N_CLASS*XLEN-1:0]        unit_result_i,
  output logic                           wb_valid_o,
  output logic [TAG_W-1:0]               wb_tag_o,
  output logic [XLEN-1:0]                wb_data_o,
  input  logic [TAG_W-1:0]               query_tag_i,
  output logic                           query_hit_o,
  output logic [$clog2(MAX_LAT+1)-1:0]   inflight_o
);

  localparam int unsigned CLS_W = $clog2(N_CLASS);
  localparam int unsigned IDX_W = $clog2(MAX_LAT);
  localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);

  logic [LAT_W-1:0]   issue_lat;
  logic               slot_busy;
  logic               iter_busy;
  logic               accept;
  logic [LAT_W-1:0]   iter_cnt_q;
  logic [CNT_W-1:0]   inflight_q;
  logic [MAX_LAT-1:0] slot_valid;
  logic [TAG_W-1:0]   head_tag;
  logic [CLS_W-1:0]   head_cls;
  logic [CNT_W-1:0]   count_next;

  assign issue_lat = CLASS_LAT[issue_class_i*LAT_W +: LAT_W];
  assign iter_busy = (iter_cnt_q != '0);

  // The slot one beyond the insert point shifts into it; an op there blocks issue.
  always_comb begin
    slot_busy = 1'b0;
    if (32'(issue_lat) < MAX_LAT) begin
      slot_busy = slot_valid[issue_lat[IDX_W-1:0]];
    end
  end

  assign issue_ready_o = ~slot_busy & ~(ITER_MASK[issue_class_i] & iter_busy) & ~flush_i;
  assign accept        = issue_valid_i & issue_ready_o;

  fpu_resv_slot_array #(
    .MAX_LAT (MAX_LAT),
    .TAG_W   (TAG_W),
    .CLS_W   (CLS_W),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) u_slots (
    .clk        (clock_float_i),
    .rst_n      (reset_i),
    .flush      (flush_i),
    .ins_en     (accept),
    .ins_idx    (IDX_W'(issue_lat - LAT_W'(1))),
    .ins_tag    (issue_tag_i),
    .ins_cls    (issue_class_i),
    .query_tag  (query_tag_i),
    .slot_valid (slot_valid),
    .head_tag   (head_tag),
    .head_cls   (head_cls),
    .query_hit  (query_hit_o),
    .count_next (count_next)
  );

  // Busy countdown for the shared non-pipelined unit; frees in its writeback cycle.
  always_ff @(posedge clock_float_i or negedge reset_i) begin
    if (!reset_i) begin
      iter_cnt_q <= '0;
    end else if (flush_i) begin
      iter_cnt_q <= '0;
    end else if (accept && ITER_MASK[issue_class_i]) begin
      iter_cnt_q <= issue_lat - LAT_W'(1);
    end else if (iter_busy) begin
      iter_cnt_q <= iter_cnt_q - LAT_W'(1);
    end
  end

  // Registered occupancy of the slots after this cycle's update.
  always_ff @(posedge clock_float_i or negedge reset_i) begin
    if (!reset_i) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= count_next;
    end
  end

  assign inflight_o = inflight_q;

  // Writeback port driven straight from slot 0; zeroed when nothing retires.
  always_comb begin
    wb_valid_o = slot_valid[0];
    wb_tag_o   = '0;
    wb_data_o  = '0;
    if (slot_valid[0]) begin
      wb_tag_o  = head_tag;
      wb_data_o = unit_result_i[head_cls*XLEN +: XLEN];
    end
  end

endmodule

// File: tb/tb_fpu_wb_scheduler.sv
// Self-checking bench for fpu_wb_scheduler: directed scenarios followed by
// random traffic, all checked against a writeback-calendar model.
module tb_fpu_wb_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         iv = 1'b0;
  logic [2:0]   icls = '0;
  logic [4:0]   itag = '0;
  logic [255:0] ures = '0;
  logic         ready;
  logic         wb_valid;
  logic [4:0]   wb_tag;
  logic [31:0]  wb_data;
  logic [4:0]   qtag = '0;
  logic         qhit;
  logic [4:0]   inflight;

  always #5 clk = ~clk;

  fpu_wb_scheduler dut (
    .clock_float_i (clk),
    .reset_i       (rst_n),
    .flush_i       (flush),
    .issue_valid_i (iv),
    .issue_ready_o (ready),
    .issue_class_i (icls),
    .issue_tag_i   (itag),
    .unit_result_i (ures),
    .wb_valid_o    (wb_valid),
    .wb_tag_o      (wb_tag),
    .wb_data_o     (wb_data),
    .query_tag_i   (qtag),
    .query_hit_o   (qhit),
    .inflight_o    (inflight)
  );

  // Class latencies: ADD_SUB MUL FMA DIV SQRT CVT CMP MISC; DIV/SQRT non-pipelined.
  int lat_tab [8] = '{4, 5, 6, 12, 14, 3, 3, 2};
  bit iter_tab[8] = '{0, 0, 0, 1, 1, 0, 0, 0};

  // Calendar of pending writebacks indexed by absolute cycle (mod 64).
  bit         pv [64];
  logic [4:0] pt [64];
  int         pc [64];
  int         cyc_n;
  int         iter_free;

  int   total = 0;
  int   bad = 0;
  logic last_ready;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) pv[i] = 1'b0;
    iter_free = 0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model after the edge.
  task automatic run_cycle(input bit v, input int cls, input int tag, input bit fl, input int qt);
    int   l;
    bit   exp_ready;
    bit   ewv;
    logic [4:0]  etag;
    logic [31:0] edata;
    int   ecnt;
    bit   ehit;
    int   slot;
    iv    = v;
    icls  = cls[2:0];
    itag  = tag[4:0];
    flush = fl;
    qtag  = qt[4:0];
    for (int s = 0; s < 8; s++) ures[s*32 +: 32] = $urandom;
    @(negedge clk);
    l = lat_tab[cls];
    exp_ready = !fl && !pv[(cyc_n + l) % 64] && !(iter_tab[cls] && (cyc_n < iter_free));
    slot  = cyc_n % 64;
    ewv   = pv[slot];
    etag  = ewv ? pt[slot] : 5'd0;
    edata = ewv ? ures[pc[slot]*32 +: 32] : 32'd0;
    ecnt  = 0;
    ehit  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (pv[i]) begin
        ecnt++;
        if (pt[i] == qt[4:0]) ehit = 1'b1;
      end
    end
    check("issue_ready", 32'(ready), 32'(exp_ready));
    check("wb_valid", 32'(wb_valid), 32'(ewv));
    check("wb_tag", 32'(wb_tag), 32'(etag));
    check("wb_data", wb_data, edata);
    check("inflight", 32'(inflight), 32'(ecnt));
    check("query_hit", 32'(qhit), 32'(ehit));
    last_ready = ready;
    @(posedge clk);
    #1;
    pv[slot] = 1'b0;
    if (fl) begin
      model_clear();
    end else if (v && exp_ready) begin
      pv[(cyc_n + l) % 64] = 1'b1;
      pt[(cyc_n + l) % 64] = tag[4:0];
      pc[(cyc_n + l) % 64] = cls;
      if (iter_tab[cls]) iter_free = cyc_n + l;
    end
    cyc_n++;
  endtask

  task automatic idle(input int n, input int qt);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 0, 0, 1'b0, qt);
  endtask

  initial begin
    int waited;
    model_clear();
    cyc_n = 0;

    // Reset values while held in reset.
    #2;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_tag", 32'(wb_tag), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_query_hit", 32'(qhit), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 0);

    // Single MUL, tag 3: writeback 5 cycles after accept, query hit meanwhile.
    run_cycle(1'b1, 1, 3, 1'b0, 3);
    check("mul_accept", 32'(last_ready), 32'd1);
    idle(7, 3);

    // ADD then CMP one cycle later collide; CMP goes one cycle later instead.
    run_cycle(1'b1, 0, 7, 1'b0, 7);
    run_cycle(1'b1, 6, 8, 1'b0, 8);
    check("cmp_refused", 32'(last_ready), 32'd0);
    run_cycle(1'b1, 6, 8, 1'b0, 8);
    check("cmp_accept", 32'(last_ready), 32'd1);
    idle(6, 7);

    // Back-to-back DIVs: second is accepted in the first one's writeback cycle.
    run_cycle(1'b1, 3, 10, 1'b0, 10);
    waited = 0;
    do begin
      run_cycle(1'b1, 3, 11, 1'b0, 11);
      waited++;
    end while (!last_ready && waited < 30);
    check("div_gap", 32'(waited), 32'd12);
    idle(14, 11);

    // Flush with three ops in flight; an op offered alongside is dropped.
    run_cycle(1'b1, 0, 1, 1'b0, 1);
    run_cycle(1'b1, 1, 2, 1'b0, 2);
    run_cycle(1'b1, 3, 4, 1'b0, 4);
    run_cycle(1'b1, 0, 5, 1'b1, 4);
    check("flush_refuses", 32'(last_ready), 32'd0);
    run_cycle(1'b1, 3, 6, 1'b0, 4);
    check("div_after_flush", 32'(last_ready), 32'd1);
    idle(14, 6);

    // Asynchronous reset mid-DIV clears outputs at once.
    run_cycle(1'b1, 3, 9, 1'b0, 9);
    idle(4, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_query_hit", 32'(qhit), 32'd0);
    check("arst_inflight", 32'(inflight), 32'd0);
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    iv   = 1'b1;
    icls = 3'd3;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    iv = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    run_cycle(1'b1, 3, 12, 1'b0, 12);
    check("div_after_reset", 32'(last_ready), 32'd1);
    idle(14, 12);

    // Random mixed traffic.
    for (int i = 0; i < 200; i++) begin
      run_cycle($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)),
                int'($urandom_range(0, 31)), $urandom_range(0, 49) == 0,
                int'($urandom_range(0, 31)));
    end
    idle(20, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
